zap_wb_arbiter: RTL and testbench
=================================

ZAP_WB_ARBITER -- requirements
Module: zap_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, sets the slave no-response limit in cycles, range 2..65535.
REQ-002 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_reset  input  1  reset, synchronous and active-high.
REQ-004 i_m{0,1}_wb_cyc  input  1  bus cycle from master 0 (core instruction port) and master 1 (core data port).
REQ-005 i_m{0,1}_wb_stb  input  1  strobe from each master.
REQ-006 i_m{0,1}_wb_we  input  1  write enable from each master.
REQ-007 i_m{0,1}_wb_sel  input  4  byte selects from each master.
REQ-008 i_m{0,1}_wb_adr  input  32  byte address from each master.
REQ-009 i_m{0,1}_wb_dat  input  32  write data from each master.
REQ-010 o_m{0,1}_wb_dat  output  32  read data to each master.
REQ-011 o_m{0,1}_wb_ack  output  1  acknowledge to each master.
REQ-012 o_m{0,1}_wb_err  output  1  error to each master.
REQ-013 o_s_wb_cyc / o_s_wb_stb / o_s_wb_we  output  1 each  cycle, strobe and write enable to the single-port slave RAM.
REQ-014 o_s_wb_sel  output  4; o_s_wb_adr  output  32; o_s_wb_dat  output  32: muxed request to the slave.
REQ-015 i_s_wb_dat  input  32; i_s_wb_ack  input  1; i_s_wb_err  input  1: slave response.

Function
REQ-016 FSM states: IDLE, OWN_M0, OWN_M1; the state is registered and the slave outputs are a combinational mux selected by the state.
REQ-017 In IDLE, all slave outputs are 0, and every master sees ack=0, err=0 and dat=0.
REQ-018 IDLE to OWN_Mx on the next edge when only master x has cyc=1; the slave sees the request 1 cycle after the master raises cyc.
REQ-019 When both masters request in IDLE, the master not recorded in the 1-bit last_grant register wins; last_grant updates to the winner on entry.
REQ-020 In OWN_Mx, all slave request signals equal master x's inputs.
REQ-021 In OWN_Mx, i_s_wb_dat, ack and err route only to master x; the other master sees ack=0, err=0 and dat=0.
REQ-022 Ownership holds while master x keeps cyc=1, even with stb=0, so multi-beat sequences are locked.
REQ-023 OWN_Mx returns to IDLE on the edge where i_mx_wb_cyc=0, which gives at least 1 idle cycle between owners.
REQ-024 A slave ack or err arriving in IDLE is discarded.
REQ-025 The non-granted master's request is held pending without any response until the next IDLE decision.

Reset
REQ-026 While i_reset=1 on an edge: state goes to IDLE, last_grant goes to M1 (so M0 wins the first tie), and the timeout counter goes to 0.
REQ-027 A reset asserted mid-transfer drops o_s_wb_cyc/stb in the cycle after the edge, and any later slave ack is discarded.

Configuration
REQ-028 With ZAP_WB_TIMEOUT_EN defined: a counter increments each cycle that o_s_wb_stb=1 with no slave ack or err.
REQ-029 With ZAP_WB_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES-1, the owner gets a 1-cycle err, o_s_wb_stb is forced to 0 for that cycle, and the counter clears. The counter also clears on ack, on err, and on leaving OWN.
REQ-030 Without ZAP_WB_TIMEOUT_EN: no counter exists, and the err output is a pure passthrough of i_s_wb_err.

Structure
REQ-031 The shared package zap_wb_pkg holds the state encoding, the M0/M1 index constants and the default TIMEOUT_CYCLES.
REQ-032 Sub-module zap_wb_timeout contains the timeout counter and is instantiated only under ZAP_WB_TIMEOUT_EN.

Verification
REQ-033 M0 alone reads 0x100, slave acks after 2 cycles with 0xDEADBEEF -> o_s_wb_cyc=1 one cycle after the request, o_m0_wb_ack=1 with dat=0xDEADBEEF, and M1 outputs stay 0.
REQ-034 Both masters request on the first cycle after reset -> M0 is granted first; after M0 drops cyc, one IDLE cycle, then M1 is granted; a second tie goes to M0 again.
REQ-035 M1 writes 0x12345678 with sel=4'b0011 to 0x7C8 while holding cyc across two strobes -> M0 is never granted during the hold, and the slave sees the exact sel/adr/dat.
REQ-036 Assert i_reset while OWN_M1 awaits an ack -> o_s_wb_cyc=0 next cycle, and a late slave ack is not seen by either master.
REQ-037 With ZAP_WB_TIMEOUT_EN and TIMEOUT_CYCLES=8, the slave never acks -> o_m0_wb_err pulses for 1 cycle on the 8th stalled cycle; without the macro, no err is raised.

Source files
------------

// File: rtl/zap_wb_pkg.sv
// rtl/zap_wb_pkg.sv - shared state encoding, master indices and timeout default for zap_wb_arbiter
package zap_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_M0 = 2'd1,
    ST_OWN_M1 = 2'd2
  } wb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

endpackage

// File: rtl/zap_wb_timeout.sv
// rtl/zap_wb_timeout.sv - slave no-response counter, built only with ZAP_WB_TIMEOUT_EN
module zap_wb_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic own,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic timeout
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count;

  // A real response in the limit cycle wins over the synthetic error.
  assign timeout = own && stb && !ack && !err && (count == LIMIT);

  always_ff @(posedge i_clk) begin
    if (i_reset || !own || ack || err || timeout) begin
      count <= '0;
    end else if (stb) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/zap_wb_arbiter.sv
// rtl/zap_wb_arbiter.sv - two-master to one-slave Wishbone arbiter with locked ownership
// Optional slave no-response timeout enabled by defining ZAP_WB_TIMEOUT_EN.
module zap_wb_arbiter
  import zap_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_m0_wb_cyc,
  input  logic        i_m0_wb_stb,
  input  logic        i_m0_wb_we,
  input  logic [3:0]  i_m0_wb_sel,
  input  logic [31:0] i_m0_wb_adr,
  input  logic [31:0] i_m0_wb_dat,
  output logic [31:0] o_m0_wb_dat,
  output logic        o_m0_wb_ack,
  output logic        o_m0_wb_err,
  input  logic        i_m1_wb_cyc,
  input  logic        i_m1_wb_stb,
  input  logic        i_m1_wb_we,
  input  logic [3:0]  i_m1_wb_sel,
  input  logic [31:0] i_m1_wb_adr,
  input  logic [31:0] i_m1_wb_dat,
  output logic [31:0] o_m1_wb_dat,
  output logic        o_m1_wb_ack,
  output logic        o_m1_wb_err,
  output logic        o_s_wb_cyc,
  output logic        o_s_wb_stb,
  output logic        o_s_wb_we,
  output logic [3:0]  o_s_wb_sel,
  output logic [31:0] o_s_wb_adr,
  output logic [31:0] o_s_wb_dat,
  input  logic [31:0] i_s_wb_dat,
  input  logic        i_s_wb_ack,
  input  logic        i_s_wb_err
);

  wb_state_t state;
  logic      last_grant;
  logic      raw_stb;
  logic      timeout_hit;
  logic      own_m0;
  logic      own_m1;

  // On a tie the master not recorded in last_grant wins.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      last_grant <= M1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_m0_wb_cyc && (!i_m1_wb_cyc || last_grant == M1)) begin
            state      <= ST_OWN_M0;
            last_grant <= M0;
          end else if (i_m1_wb_cyc) begin
            state      <= ST_OWN_M1;
            last_grant <= M1;
          end
        end
        ST_OWN_M0: if (!i_m0_wb_cyc) state <= ST_IDLE;
        ST_OWN_M1: if (!i_m1_wb_cyc) state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign own_m0 = (state == ST_OWN_M0);
  assign own_m1 = (state == ST_OWN_M1);

  always_comb begin
    o_s_wb_cyc = 1'b0;
    raw_stb    = 1'b0;
    o_s_wb_we  = 1'b0;
    o_s_wb_sel = '0;
    o_s_wb_adr = '0;
    o_s_wb_dat = '0;
    if (own_m0) begin
      o_s_wb_cyc = i_m0_wb_cyc;
      raw_stb    = i_m0_wb_stb;
      o_s_wb_we  = i_m0_wb_we;
      o_s_wb_sel = i_m0_wb_sel;
      o_s_wb_adr = i_m0_wb_adr;
      o_s_wb_dat = i_m0_wb_dat;
    end else if (own_m1) begin
      o_s_wb_cyc = i_m1_wb_cyc;
      raw_stb    = i_m1_wb_stb;
      o_s_wb_we  = i_m1_wb_we;
      o_s_wb_sel = i_m1_wb_sel;
      o_s_wb_adr = i_m1_wb_adr;
      o_s_wb_dat = i_m1_wb_dat;
    end
  end

`ifdef ZAP_WB_TIMEOUT_EN
  zap_wb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .own     (own_m0 || own_m1),
    .stb     (raw_stb),
    .ack     (i_s_wb_ack),
    .err     (i_s_wb_err),
    .timeout (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Responses reach only the current owner; anything arriving in IDLE is dropped.
  assign o_s_wb_stb  = raw_stb && !timeout_hit;
  assign o_m0_wb_ack = own_m0 && i_s_wb_ack;
  assign o_m1_wb_ack = own_m1 && i_s_wb_ack;
  assign o_m0_wb_err = own_m0 && (i_s_wb_err || timeout_hit);
  assign o_m1_wb_err = own_m1 && (i_s_wb_err || timeout_hit);
  assign o_m0_wb_dat = own_m0 ? i_s_wb_dat : 32'd0;
  assign o_m1_wb_dat = own_m1 ? i_s_wb_dat : 32'd0;

endmodule

// File: tb/tb_zap_wb_arbiter.sv
// tb/tb_zap_wb_arbiter.sv - self-checking bench for zap_wb_arbiter (follows ZAP_WB_TIMEOUT_EN)
module tb_zap_wb_arbiter;

  localparam int T = 8;
`ifdef ZAP_WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] sdat;
    logic [31:0] m0dat;
    logic        m0ack;
    logic        m0err;
    logic [31:0] m1dat;
    logic        m1ack;
    logic        m1err;
  } bus_t;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_m0_wb_cyc, i_m0_wb_stb, i_m0_wb_we;
  logic [3:0]  i_m0_wb_sel;
  logic [31:0] i_m0_wb_adr, i_m0_wb_dat;
  logic [31:0] o_m0_wb_dat;
  logic        o_m0_wb_ack, o_m0_wb_err;
  logic        i_m1_wb_cyc, i_m1_wb_stb, i_m1_wb_we;
  logic [3:0]  i_m1_wb_sel;
  logic [31:0] i_m1_wb_adr, i_m1_wb_dat;
  logic [31:0] o_m1_wb_dat;
  logic        o_m1_wb_ack, o_m1_wb_err;
  logic        o_s_wb_cyc, o_s_wb_stb, o_s_wb_we;
  logic [3:0]  o_s_wb_sel;
  logic [31:0] o_s_wb_adr, o_s_wb_dat;
  logic [31:0] i_s_wb_dat;
  logic        i_s_wb_ack, i_s_wb_err;

  int checks = 0;
  int failures = 0;

  // Reference model: owner is -1 when nobody holds the bus.
  int m_owner = -1;
  int m_last = 1;
  int m_tcnt = 0;

  always #5 i_clk = ~i_clk;

  zap_wb_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_m0_wb_cyc(i_m0_wb_cyc), .i_m0_wb_stb(i_m0_wb_stb), .i_m0_wb_we(i_m0_wb_we),
    .i_m0_wb_sel(i_m0_wb_sel), .i_m0_wb_adr(i_m0_wb_adr), .i_m0_wb_dat(i_m0_wb_dat),
    .o_m0_wb_dat(o_m0_wb_dat), .o_m0_wb_ack(o_m0_wb_ack), .o_m0_wb_err(o_m0_wb_err),
    .i_m1_wb_cyc(i_m1_wb_cyc), .i_m1_wb_stb(i_m1_wb_stb), .i_m1_wb_we(i_m1_wb_we),
    .i_m1_wb_sel(i_m1_wb_sel), .i_m1_wb_adr(i_m1_wb_adr), .i_m1_wb_dat(i_m1_wb_dat),
    .o_m1_wb_dat(o_m1_wb_dat), .o_m1_wb_ack(o_m1_wb_ack), .o_m1_wb_err(o_m1_wb_err),
    .o_s_wb_cyc(o_s_wb_cyc), .o_s_wb_stb(o_s_wb_stb), .o_s_wb_we(o_s_wb_we),
    .o_s_wb_sel(o_s_wb_sel), .o_s_wb_adr(o_s_wb_adr), .o_s_wb_dat(o_s_wb_dat),
    .i_s_wb_dat(i_s_wb_dat), .i_s_wb_ack(i_s_wb_ack), .i_s_wb_err(i_s_wb_err)
  );

  function automatic logic owner_stb();
    if (m_owner == 0) return i_m0_wb_stb;
    if (m_owner == 1) return i_m1_wb_stb;
    return 1'b0;
  endfunction

  function automatic logic model_fire();
    return TO_EN && owner_stb() && !i_s_wb_ack && !i_s_wb_err && (m_tcnt == T - 1);
  endfunction

  function automatic bus_t model_out();
    bus_t e;
    logic f;
    e = '0;
    f = model_fire();
    if (m_owner == 0) begin
      e.cyc = i_m0_wb_cyc; e.stb = i_m0_wb_stb & ~f; e.we = i_m0_wb_we;
      e.sel = i_m0_wb_sel; e.adr = i_m0_wb_adr; e.sdat = i_m0_wb_dat;
      e.m0dat = i_s_wb_dat; e.m0ack = i_s_wb_ack; e.m0err = i_s_wb_err | f;
    end else if (m_owner == 1) begin
      e.cyc = i_m1_wb_cyc; e.stb = i_m1_wb_stb & ~f; e.we = i_m1_wb_we;
      e.sel = i_m1_wb_sel; e.adr = i_m1_wb_adr; e.sdat = i_m1_wb_dat;
      e.m1dat = i_s_wb_dat; e.m1ack = i_s_wb_ack; e.m1err = i_s_wb_err | f;
    end
    return e;
  endfunction

  function automatic bus_t dut_out();
    return '{o_s_wb_cyc, o_s_wb_stb, o_s_wb_we, o_s_wb_sel, o_s_wb_adr, o_s_wb_dat,
             o_m0_wb_dat, o_m0_wb_ack, o_m0_wb_err, o_m1_wb_dat, o_m1_wb_ack, o_m1_wb_err};
  endfunction

  // Advance one clock, updating the model from the inputs sampled at that edge.
  task automatic tick();
    int n_owner, n_last, n_tcnt;
    n_owner = m_owner; n_last = m_last; n_tcnt = m_tcnt;
    if (i_reset) begin
      n_owner = -1; n_last = 1; n_tcnt = 0;
    end else begin
      if (m_owner < 0 || i_s_wb_ack || i_s_wb_err || model_fire()) n_tcnt = 0;
      else if (owner_stb()) n_tcnt = m_tcnt + 1;
      if (m_owner < 0) begin
        if (i_m0_wb_cyc && i_m1_wb_cyc) n_owner = 1 - m_last;
        else if (i_m0_wb_cyc) n_owner = 0;
        else if (i_m1_wb_cyc) n_owner = 1;
        if (n_owner >= 0) n_last = n_owner;
      end else if ((m_owner == 0 && !i_m0_wb_cyc) || (m_owner == 1 && !i_m1_wb_cyc)) begin
        n_owner = -1;
      end
    end
    @(posedge i_clk);
    m_owner = n_owner; m_last = n_last; m_tcnt = n_tcnt;
    #1;
  endtask

  task automatic clear_inputs();
    i_m0_wb_cyc = 0; i_m0_wb_stb = 0; i_m0_wb_we = 0; i_m0_wb_sel = 0; i_m0_wb_adr = 0; i_m0_wb_dat = 0;
    i_m1_wb_cyc = 0; i_m1_wb_stb = 0; i_m1_wb_we = 0; i_m1_wb_sel = 0; i_m1_wb_adr = 0; i_m1_wb_dat = 0;
    i_s_wb_dat = 0; i_s_wb_ack = 0; i_s_wb_err = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_reset = 1;
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_adr = 32'h44;
    tick(); tick();
    @(negedge i_clk);
    checks++; if (o_s_wb_cyc !== 1'b0) begin failures++; $display("FAIL reset_s_cyc got=%0b want=0", o_s_wb_cyc); end
    checks++; if (o_s_wb_stb !== 1'b0) begin failures++; $display("FAIL reset_s_stb got=%0b want=0", o_s_wb_stb); end
    checks++; if (o_s_wb_adr !== 32'h0) begin failures++; $display("FAIL reset_s_adr got=%h want=0", o_s_wb_adr); end
    checks++; if ({o_m0_wb_ack, o_m1_wb_ack, o_m0_wb_err, o_m1_wb_err} !== 4'b0) begin
      failures++; $display("FAIL reset_resp got=%b want=0000", {o_m0_wb_ack, o_m1_wb_ack, o_m0_wb_err, o_m1_wb_err});
    end
    clear_inputs();
    i_reset = 0;
    tick();
  endtask

  task automatic test_m0_read();
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_we = 0; i_m0_wb_sel = 4'hF; i_m0_wb_adr = 32'h100;
    @(negedge i_clk);
    checks++; if (o_s_wb_cyc !== 1'b0) begin failures++; $display("FAIL read_no_early_cyc got=%0b want=0", o_s_wb_cyc); end
    tick();
    @(negedge i_clk);
    checks++; if (o_s_wb_cyc !== 1'b1) begin failures++; $display("FAIL read_s_cyc got=%0b want=1", o_s_wb_cyc); end
    checks++; if (o_s_wb_adr !== 32'h100) begin failures++; $display("FAIL read_s_adr got=%h want=00000100", o_s_wb_adr); end
    tick();
    i_s_wb_ack = 1; i_s_wb_dat = 32'hDEADBEEF;
    @(negedge i_clk);
    checks++; if (o_m0_wb_ack !== 1'b1) begin failures++; $display("FAIL read_m0_ack got=%0b want=1", o_m0_wb_ack); end
    checks++; if (o_m0_wb_dat !== 32'hDEADBEEF) begin failures++; $display("FAIL read_m0_dat got=%h want=deadbeef", o_m0_wb_dat); end
    checks++; if ({o_m1_wb_ack, o_m1_wb_err, o_m1_wb_dat} !== 34'h0) begin
      failures++; $display("FAIL read_m1_quiet got=%b/%b/%h want=0/0/0", o_m1_wb_ack, o_m1_wb_err, o_m1_wb_dat);
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_tie();
    i_reset = 1;
    tick();
    i_reset = 0;
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_adr = 32'hA0;
    i_m1_wb_cyc = 1; i_m1_wb_stb = 1; i_m1_wb_adr = 32'hB0;
    tick();
    i_s_wb_ack = 1; i_s_wb_dat = 32'h55;
    @(negedge i_clk);
    checks++; if (o_s_wb_adr !== 32'hA0) begin failures++; $display("FAIL tie1_winner adr got=%h want=000000a0", o_s_wb_adr); end
    checks++; if (o_m1_wb_ack !== 1'b0) begin failures++; $display("FAIL tie1_m1_pending ack got=%0b want=0", o_m1_wb_ack); end
    i_s_wb_ack = 0;
    i_m0_wb_cyc = 0; i_m0_wb_stb = 0;
    tick();
    @(negedge i_clk);
    checks++; if (o_s_wb_cyc !== 1'b0) begin failures++; $display("FAIL tie_idle_gap cyc got=%0b want=0", o_s_wb_cyc); end
    tick();
    @(negedge i_clk);
    checks++; if (o_s_wb_adr !== 32'hB0) begin failures++; $display("FAIL tie_m1_next adr got=%h want=000000b0", o_s_wb_adr); end
    i_m1_wb_cyc = 0; i_m1_wb_stb = 0;
    tick();
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m1_wb_cyc = 1; i_m1_wb_stb = 1;
    tick();
    @(negedge i_clk);
    checks++; if (o_s_wb_adr !== 32'hA0) begin failures++; $display("FAIL tie2_winner adr got=%h want=000000a0", o_s_wb_adr); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_locked_write();
    i_m1_wb_cyc = 1; i_m1_wb_stb = 1; i_m1_wb_we = 1; i_m1_wb_sel = 4'b0011;
    i_m1_wb_adr = 32'h7C8; i_m1_wb_dat = 32'h12345678;
    tick();
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_adr = 32'h40;
    i_s_wb_ack = 1;
    @(negedge i_clk);
    checks++; if ({o_s_wb_we, o_s_wb_sel, o_s_wb_adr, o_s_wb_dat} !== {1'b1, 4'b0011, 32'h7C8, 32'h12345678}) begin
      failures++; $display("FAIL lock_req got=%0b/%b/%h/%h want=1/0011/000007c8/12345678", o_s_wb_we, o_s_wb_sel, o_s_wb_adr, o_s_wb_dat);
    end
    checks++; if ({o_m1_wb_ack, o_m0_wb_ack} !== 2'b10) begin failures++; $display("FAIL lock_beat1 acks got=%b want=10", {o_m1_wb_ack, o_m0_wb_ack}); end
    tick();
    i_m1_wb_stb = 0; i_s_wb_ack = 0;
    @(negedge i_clk);
    checks++; if ({o_s_wb_cyc, o_s_wb_stb, o_s_wb_adr} !== {2'b10, 32'h7C8}) begin
      failures++; $display("FAIL lock_gap got=%0b/%0b/%h want=1/0/000007c8", o_s_wb_cyc, o_s_wb_stb, o_s_wb_adr);
    end
    tick();
    i_m1_wb_stb = 1; i_s_wb_ack = 1;
    @(negedge i_clk);
    checks++; if ({o_s_wb_adr, o_m0_wb_ack, o_m1_wb_ack} !== {32'h7C8, 2'b01}) begin
      failures++; $display("FAIL lock_beat2 got=%h/%0b/%0b want=000007c8/0/1", o_s_wb_adr, o_m0_wb_ack, o_m1_wb_ack);
    end
    tick();
    i_m1_wb_cyc = 0; i_m1_wb_stb = 0; i_m1_wb_we = 0; i_s_wb_ack = 0;
    tick();
    @(negedge i_clk);
    checks++; if (o_s_wb_cyc !== 1'b0) begin failures++; $display("FAIL lock_release cyc got=%0b want=0", o_s_wb_cyc); end
    tick();
    @(negedge i_clk);
    checks++; if (o_s_wb_adr !== 32'h40) begin failures++; $display("FAIL lock_m0_after adr got=%h want=00000040", o_s_wb_adr); end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    i_m1_wb_cyc = 1; i_m1_wb_stb = 1; i_m1_wb_adr = 32'h200;
    tick();
    @(negedge i_clk);
    checks++; if (o_s_wb_cyc !== 1'b1) begin failures++; $display("FAIL rstmid_owned cyc got=%0b want=1", o_s_wb_cyc); end
    i_reset = 1;
    tick();
    i_s_wb_ack = 1; i_s_wb_dat = 32'hCAFE;
    @(negedge i_clk);
    checks++; if ({o_s_wb_cyc, o_s_wb_stb} !== 2'b00) begin failures++; $display("FAIL rstmid_drop got=%b want=00", {o_s_wb_cyc, o_s_wb_stb}); end
    checks++; if ({o_m0_wb_ack, o_m1_wb_ack} !== 2'b00) begin failures++; $display("FAIL rstmid_late_ack got=%b want=00", {o_m0_wb_ack, o_m1_wb_ack}); end
    i_reset = 0; i_m1_wb_cyc = 0; i_m1_wb_stb = 0;
    @(negedge i_clk);
    checks++; if ({o_m0_wb_ack, o_m1_wb_ack, o_m1_wb_dat} !== 34'h0) begin
      failures++; $display("FAIL rstmid_idle_ack got=%0b/%0b/%h want=0/0/0", o_m0_wb_ack, o_m1_wb_ack, o_m1_wb_dat);
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_timeout();
    logic want_err;
    i_m0_wb_cyc = 1; i_m0_wb_stb = 1; i_m0_wb_adr = 32'h300;
    tick();
    for (int k = 1; k <= 12; k++) begin
      want_err = TO_EN && (k == T);
      @(negedge i_clk);
      checks++; if (o_m0_wb_err !== want_err) begin failures++; $display("FAIL timeout_err stall=%0d got=%0b want=%0b", k, o_m0_wb_err, want_err); end
      checks++; if (o_s_wb_stb !== !want_err) begin failures++; $display("FAIL timeout_stb stall=%0d got=%0b want=%0b", k, o_s_wb_stb, !want_err); end
      tick();
    end
    clear_inputs();
    tick(); tick();
  endtask

  task automatic test_random();
    bus_t exp_v, act_v;
    for (int n = 0; n < 400; n++) begin
      i_reset = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) i_m0_wb_cyc = ~i_m0_wb_cyc;
      if ($urandom_range(0, 3) == 0) i_m1_wb_cyc = ~i_m1_wb_cyc;
      i_m0_wb_stb = 1'($urandom); i_m0_wb_we = 1'($urandom); i_m0_wb_sel = 4'($urandom);
      i_m0_wb_adr = $urandom; i_m0_wb_dat = $urandom;
      i_m1_wb_stb = 1'($urandom); i_m1_wb_we = 1'($urandom); i_m1_wb_sel = 4'($urandom);
      i_m1_wb_adr = $urandom; i_m1_wb_dat = $urandom;
      i_s_wb_ack = ($urandom_range(0, 2) == 0);
      i_s_wb_err = ($urandom_range(0, 15) == 0);
      i_s_wb_dat = $urandom;
      @(negedge i_clk);
      exp_v = model_out();
      act_v = dut_out();
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL random cycle=%0d owner=%0d got=%h want=%h", n, m_owner, act_v, exp_v);
      end
      tick();
    end
    clear_inputs();
    i_reset = 0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_m0_read();
    test_tie();
    test_locked_write();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
